miriscv_boot_ctrl: RTL and testbench
====================================

Name: miriscv_boot_ctrl

Overview:
Boot/run sequencer for the miriscv_top system. It holds the core in reset and streams a program image into the instruction/data RAM through a dedicated write port. It then releases the core for a bounded run and freezes it on halt or budget expiry, so benches and the host interface can inspect architectural state. It replaces ad-hoc direct memory pokes with a defined load/reset/run/done handshake.

Parameters:
RAM_SIZE, 512, RAM depth in 32-bit words; ADDR_W = $clog2(RAM_SIZE) is derived locally.
RST_HOLD, 2, cycles core_rst_n_o is held low between the end of the load and the run; must be at least 1.
RUN_CYCLES, 300, maximum core run length in cycles; must be at least 1.

Ports:
clk_i  in  1  system clock, all logic on the rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
load_start_i  in  1  single-cycle request to begin a load; sampled in IDLE and DONE only.
load_len_i  in  ADDR_W+1  number of words to load; sampled with load_start_i.
abort_i  in  1  forces a return to IDLE from any state.
word_valid_i  in  1  program word valid.
word_data_i  in  32  program word, little-endian as stored in RAM.
word_ready_o  out  1  controller accepts a word.
ram_we_o  out  1  RAM write enable.
ram_addr_o  out  32  RAM byte address (word index << 2).
ram_wdata_o  out  32  RAM write data.
core_rst_n_o  out  1  active-low core reset.
core_stall_o  out  1  core clock-enable inhibit.
core_halt_i  in  1  core signals program end.
busy_o  out  1  high in LOAD, RST_HOLD and RUN.
done_o  out  1  high in DONE.
timeout_o  out  1  set when a run ended on budget expiry.
err_o  out  1  one-cycle pulse on a rejected load request.
cycles_o  out  32  core cycles executed in the last or current run.

Behaviour:
- Reset (async assert): state IDLE. core_rst_n_o=0. All other outputs 0, including cycles_o.
- States: IDLE, LOAD, HOLD, RUN, DONE. State, counters and every output except word_ready_o are registered.
- IDLE/DONE, load_start_i=1:
  - load_len_i in 1..RAM_SIZE: go to LOAD next cycle. Word counter cleared; timeout_o and cycles_o cleared; done_o drops; core_rst_n_o=0; core_stall_o=0.
  - load_len_i = 0 or > RAM_SIZE: err_o pulses for 1 cycle and the state is unchanged.
- load_start_i in LOAD, HOLD or RUN: ignored, no err_o.
- LOAD:
  - word_ready_o=1, driven combinationally from the state.
  - A handshake is word_valid_i & word_ready_o. One cycle after each handshake: ram_we_o=1, ram_addr_o = index*4, ram_wdata_o = the data word. Write latency is exactly 1 cycle.
  - Back-to-back handshakes produce back-to-back writes. When valid is low, ram_we_o=0 and the index holds.
  - When the handshake with index = len-1 occurs, the next state is HOLD and word_ready_o is 0 the following cycle. The final write issues in the first HOLD cycle.
- HOLD: core_rst_n_o=0 for exactly RST_HOLD cycles, then RUN.
- RUN:
  - core_rst_n_o=1, core_stall_o=0. cycles_o increments by 1 each RUN cycle, starting at 1 on the first.
  - core_halt_i=1: go to DONE with timeout_o=0.
  - Otherwise, when cycles_o reaches RUN_CYCLES: go to DONE with timeout_o=1.
  - Halt in the same cycle as expiry: halt wins and timeout_o=0.
- DONE:
  - done_o=1, core_stall_o=1, core_rst_n_o=1 so register file and RAM state stay readable. cycles_o frozen.
  - Exits only via load_start_i or abort_i.
- abort_i (priority over everything except reset): next state IDLE. core_rst_n_o=0, core_stall_o=0, ram_we_o=0. The counters are cleared.
  - A word handshaked in the abort cycle is not written.
  - If abort_i arrives the cycle after a handshake, that pending write still completes.
- busy_o = (state in LOAD, HOLD, RUN). It is registered and matches the state.
- Reset asserted mid-run: immediate IDLE. RAM contents are untouched by the controller.

Test Plan:
1. Normal load: after reset, load_start_i=1 with len=3; stream 0x00400093, 0x00100113, 0x00000073 with valid held high -> writes to addresses 0x0, 0x4, 0x8 on consecutive cycles, each 1 cycle after its handshake. core_rst_n_o is low for 2 cycles after the last handshake cycle, then high.
2. Halt: after scenario 1, drive core_halt_i on the 10th RUN cycle -> done_o=1, timeout_o=0, cycles_o=10, core_stall_o=1, core_rst_n_o=1.
3. Timeout: core_halt_i held 0 -> DONE after exactly 300 RUN cycles, timeout_o=1, cycles_o=300. Repeat with halt in cycle 300 -> timeout_o=0.
4. Backpressure and boundary: len=512 with word_valid_i toggled every other cycle -> 512 writes, last at address 0x7FC, none skipped or duplicated. Then len=513 and len=0 -> one err_o pulse each, state unchanged.
5. Abort: abort_i in LOAD after 2 of 5 words -> IDLE next cycle, word_ready_o=0, only 2 writes. Abort in RUN -> core_rst_n_o=0 next cycle, busy_o=0.
6. Async reset asserted mid-RUN between clock edges -> outputs reach reset values without a clock edge. After release, a new load works.

Source files
------------

// File: rtl/miriscv_boot_ctrl.sv
// Boot/run sequencer: loads a program image into RAM with the core held in reset,
// then runs the core for a bounded number of cycles and freezes it for inspection.
module miriscv_boot_ctrl #(
  parameter  int RAM_SIZE   = 512,
  parameter  int RST_HOLD   = 2,
  parameter  int RUN_CYCLES = 300,
  localparam int ADDR_W     = $clog2(RAM_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              abort_i,
  input  logic              word_valid_i,
  input  logic [31:0]       word_data_i,
  output logic              word_ready_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic              core_rst_n_o,
  output logic              core_stall_o,
  input  logic              core_halt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              err_o,
  output logic [31:0]       cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_MAX_LEN   = (ADDR_W + 1)'(RAM_SIZE);
  localparam logic [31:0]     LP_HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0]     LP_RUN_MAX   = 32'(RUN_CYCLES);

  state_t          r_state;
  state_t          w_next;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_idx;
  logic [31:0]     r_hold_cnt;
  logic [31:0]     r_cycles;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic            r_core_rst_n;
  logic            r_stall;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic            r_err;

  logic            w_hs;
  logic            w_last;
  logic            w_idle_like;
  logic            w_len_ok;
  logic            w_start_ok;
  logic            w_start_bad;

  assign word_ready_o = (r_state == S_LOAD);
  assign w_hs         = word_valid_i & word_ready_o;
  assign w_last       = (r_idx == (r_len - 1'b1));
  assign w_idle_like  = (r_state == S_IDLE) | (r_state == S_DONE);
  assign w_len_ok     = (load_len_i != '0) && (load_len_i <= LP_MAX_LEN);
  assign w_start_ok   = w_idle_like & load_start_i & w_len_ok & ~abort_i;
  assign w_start_bad  = w_idle_like & load_start_i & ~w_len_ok & ~abort_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_next = S_LOAD;
      S_LOAD:         if (w_hs && w_last) w_next = S_HOLD;
      S_HOLD:         if (r_hold_cnt == LP_HOLD_LAST) w_next = S_RUN;
      S_RUN: begin
        // Halt takes precedence over budget expiry in the same cycle.
        if (core_halt_i)                 w_next = S_DONE;
        else if (r_cycles == LP_RUN_MAX) w_next = S_DONE;
      end
      default:        w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      r_cycles   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (abort_i) begin
        // A word accepted in the abort cycle is dropped; an already-issued write is not recalled.
        r_idx      <= '0;
        r_hold_cnt <= '0;
        r_cycles   <= '0;
        r_timeout  <= 1'b0;
        r_we       <= 1'b0;
      end else begin
        r_we <= w_hs;
        if (w_start_ok) begin
          r_len     <= load_len_i;
          r_idx     <= '0;
          r_cycles  <= '0;
          r_timeout <= 1'b0;
        end
        if (w_hs) begin
          r_addr  <= 32'(r_idx) << 2;
          r_wdata <= word_data_i;
          r_idx   <= r_idx + 1'b1;
        end
        r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 32'd1 : '0;
        if (w_next == S_RUN) r_cycles <= r_cycles + 32'd1;
        if ((r_state == S_RUN) && (w_next == S_DONE)) r_timeout <= ~core_halt_i;
      end
    end
  end

  // Status and core controls are registered from the next state so they track it exactly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_core_rst_n <= 1'b0;
      r_stall      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_core_rst_n <= (w_next == S_RUN) || (w_next == S_DONE);
      r_stall      <= (w_next == S_DONE);
      r_busy       <= (w_next == S_LOAD) || (w_next == S_HOLD) || (w_next == S_RUN);
      r_done       <= (w_next == S_DONE);
    end
  end

  assign ram_we_o     = r_we;
  assign ram_addr_o   = r_addr;
  assign ram_wdata_o  = r_wdata;
  assign core_rst_n_o = r_core_rst_n;
  assign core_stall_o = r_stall;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign timeout_o    = r_timeout;
  assign err_o        = r_err;
  assign cycles_o     = r_cycles;

endmodule

// File: tb/tb_miriscv_boot_ctrl.sv
// Bench for miriscv_boot_ctrl: randomized loads and runs checked against a RAM-image
// model and cycle-count rules kept in the bench.
module tb_miriscv_boot_ctrl;

  localparam int RAM_SIZE   = 512;
  localparam int RST_HOLD   = 2;
  localparam int RUN_CYCLES = 300;
  localparam int ADDR_W     = 9;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              load_start_i = 1'b0;
  logic [ADDR_W:0]   load_len_i = '0;
  logic              abort_i = 1'b0;
  logic              word_valid_i = 1'b0;
  logic [31:0]       word_data_i = '0;
  logic              word_ready_o;
  logic              ram_we_o;
  logic [31:0]       ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic              core_rst_n_o;
  logic              core_stall_o;
  logic              core_halt_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;
  logic              err_o;
  logic [31:0]       cycles_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  logic [31:0] img [RAM_SIZE];
  logic [31:0] mem_model [RAM_SIZE];

  miriscv_boot_ctrl #(
    .RAM_SIZE(RAM_SIZE), .RST_HOLD(RST_HOLD), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_start_i(load_start_i), .load_len_i(load_len_i),
    .abort_i(abort_i), .word_valid_i(word_valid_i), .word_data_i(word_data_i),
    .word_ready_o(word_ready_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .core_rst_n_o(core_rst_n_o), .core_stall_o(core_stall_o),
    .core_halt_i(core_halt_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .err_o(err_o), .cycles_o(cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: captures every write the controller issues.
  always @(negedge clk_i) begin
    if (rst_n_i && ram_we_o) begin
      mem_model[ram_addr_o[ADDR_W+1:2]] = ram_wdata_o;
      wr_count = wr_count + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Loads img[0..len-1]; mode 0 = valid always high, 1 = every other cycle, 2 = random.
  // Returns in the first RUN cycle.
  task automatic do_load(input int len, input int mode);
    int hs, guard, low, bad;
    bit cur;
    for (int i = 0; i < RAM_SIZE; i++) mem_model[i] = 32'hDEAD_BEEF;
    wr_count = 0;
    load_start_i = 1'b1;
    load_len_i   = (ADDR_W + 1)'(len);
    step();
    load_start_i = 1'b0;
    n_chk++; if (busy_o !== 1'b1 || core_rst_n_o !== 1'b0 || cycles_o !== 32'd0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL load_enter: busy=%b rst_n=%b cycles=%0d done=%b, want 1 0 0 0", busy_o, core_rst_n_o, cycles_o, done_o);
    end
    hs = 0; guard = 0;
    while (hs < len) begin
      case (mode)
        0:       word_valid_i = 1'b1;
        1:       word_valid_i = (guard % 2) == 0;
        default: word_valid_i = 1'($urandom_range(0, 1));
      endcase
      word_data_i = img[hs];
      n_chk++; if (word_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL load_ready: word %0d ready=%b want 1", hs, word_ready_o);
      end
      cur = word_valid_i;
      step();
      n_chk++; if (ram_we_o !== cur) begin
        n_fail++; $display("FAIL write_latency: word %0d we=%b want %b", hs, ram_we_o, cur);
      end
      if (cur) begin
        n_chk++; if (ram_addr_o !== 32'(hs * 4) || ram_wdata_o !== img[hs]) begin
          n_fail++; $display("FAIL write_data: addr=%h data=%h want %h %h", ram_addr_o, ram_wdata_o, hs * 4, img[hs]);
        end
        hs++;
      end
      guard++;
      if (guard > 4 * len + 20) begin
        n_chk++; n_fail++; $display("FAIL load_budget: %0d of %0d words accepted", hs, len);
        break;
      end
    end
    word_valid_i = 1'b0;
    n_chk++; if (word_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_last: ready=%b want 0", word_ready_o);
    end
    low = 0;
    while (core_rst_n_o === 1'b0 && low < 20) begin
      low++;
      step();
    end
    n_chk++; if (low !== RST_HOLD) begin
      n_fail++; $display("FAIL hold_len: core reset low %0d cycles want %0d", low, RST_HOLD);
    end
    n_chk++; if (cycles_o !== 32'd1 || busy_o !== 1'b1 || core_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL run_first: cycles=%0d busy=%b stall=%b want 1 1 0", cycles_o, busy_o, core_stall_o);
    end
    bad = 0;
    for (int i = 0; i < len; i++) if (mem_model[i] !== img[i]) bad++;
    n_chk++; if (wr_count !== len || bad !== 0) begin
      n_fail++; $display("FAIL ram_image: writes=%0d bad=%0d want %0d 0", wr_count, bad, len);
    end
  endtask

  // Entered in RUN cycle 1; halts in RUN cycle k.
  task automatic run_halt(input int k);
    repeat (k - 1) step();
    n_chk++; if (cycles_o !== 32'(k) || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL run_count: cycles=%0d busy=%b want %0d 1", cycles_o, busy_o, k);
    end
    core_halt_i = 1'b1;
    step();
    core_halt_i = 1'b0;
    n_chk++; if (done_o !== 1'b1 || timeout_o !== 1'b0 || cycles_o !== 32'(k) ||
                 core_stall_o !== 1'b1 || core_rst_n_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_done: done=%b to=%b cycles=%0d stall=%b rst_n=%b busy=%b want 1 0 %0d 1 1 0",
                         done_o, timeout_o, cycles_o, core_stall_o, core_rst_n_o, busy_o, k);
    end
    repeat (3) step();
    n_chk++; if (done_o !== 1'b1 || cycles_o !== 32'(k)) begin
      n_fail++; $display("FAIL done_frozen: done=%b cycles=%0d want 1 %0d", done_o, cycles_o, k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_chk++; if ({core_rst_n_o, busy_o, done_o, word_ready_o, ram_we_o, core_stall_o, timeout_o, err_o} !== 8'b0 ||
                 cycles_o !== 32'd0 || ram_addr_o !== 32'd0 || ram_wdata_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: outs=%b cycles=%0d addr=%h wdata=%h want all 0",
                         {core_rst_n_o, busy_o, done_o, word_ready_o, ram_we_o, core_stall_o, timeout_o, err_o},
                         cycles_o, ram_addr_o, ram_wdata_o);
    end
    rst_n_i = 1'b1;
    step();
    n_chk++; if (busy_o !== 1'b0 || word_ready_o !== 1'b0 || core_rst_n_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b ready=%b rst_n=%b want 0 0 0", busy_o, word_ready_o, core_rst_n_o);
    end
  endtask

  task automatic test_normal_load();
    img[0] = 32'h0040_0093; img[1] = 32'h0010_0113; img[2] = 32'h0000_0073;
    do_load(3, 0);
  endtask

  task automatic test_halt();
    run_halt(10);
    for (int it = 0; it < 3; it++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) img[i] = $urandom;
      do_load(len, 2);
      run_halt($urandom_range(1, 40));
    end
  endtask

  task automatic test_timeout();
    int n;
    img[0] = $urandom; img[1] = $urandom;
    do_load(2, 0);
    n = 1;
    while (done_o !== 1'b1 && n < 400) begin
      step();
      if (done_o !== 1'b1) n++;
    end
    n_chk++; if (n !== RUN_CYCLES || cycles_o !== 32'(RUN_CYCLES) || timeout_o !== 1'b1 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_run: run=%0d cycles=%0d to=%b done=%b want %0d %0d 1 1",
                         n, cycles_o, timeout_o, done_o, RUN_CYCLES, RUN_CYCLES);
    end
    do_load(2, 0);
    n_chk++; if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_cleared: to=%b want 0", timeout_o);
    end
    run_halt(RUN_CYCLES);
  endtask

  task automatic test_ignore_start();
    img[0] = $urandom;
    do_load(1, 0);
    load_start_i = 1'b1; load_len_i = 10'd4;
    step();
    load_start_i = 1'b0;
    n_chk++; if (err_o !== 1'b0 || busy_o !== 1'b1 || core_rst_n_o !== 1'b1 || cycles_o !== 32'd2) begin
      n_fail++; $display("FAIL start_in_run: err=%b busy=%b rst_n=%b cycles=%0d want 0 1 1 2", err_o, busy_o, core_rst_n_o, cycles_o);
    end
    core_halt_i = 1'b1;
    step();
    core_halt_i = 1'b0;
    n_chk++; if (done_o !== 1'b1 || cycles_o !== 32'd2) begin
      n_fail++; $display("FAIL start_in_run_halt: done=%b cycles=%0d want 1 2", done_o, cycles_o);
    end
  endtask

  task automatic test_backpressure();
    int bad_lens [2];
    bad_lens[0] = RAM_SIZE + 1; bad_lens[1] = 0;
    for (int i = 0; i < RAM_SIZE; i++) img[i] = $urandom;
    do_load(RAM_SIZE, 1);
    run_halt(5);
    for (int b = 0; b < 2; b++) begin
      load_start_i = 1'b1; load_len_i = (ADDR_W + 1)'(bad_lens[b]);
      step();
      load_start_i = 1'b0;
      n_chk++; if (err_o !== 1'b1 || done_o !== 1'b1 || busy_o !== 1'b0 || word_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bad_len_err: len=%0d err=%b done=%b busy=%b ready=%b want 1 1 0 0",
                           bad_lens[b], err_o, done_o, busy_o, word_ready_o);
      end
      step();
      n_chk++; if (err_o !== 1'b0 || done_o !== 1'b1 || cycles_o !== 32'd5) begin
        n_fail++; $display("FAIL bad_len_pulse: len=%0d err=%b done=%b cycles=%0d want 0 1 5", bad_lens[b], err_o, done_o, cycles_o);
      end
    end
  endtask

  task automatic test_abort_load();
    for (int i = 0; i < 5; i++) img[i] = $urandom;
    for (int i = 0; i < RAM_SIZE; i++) mem_model[i] = 32'hDEAD_BEEF;
    wr_count = 0;
    load_start_i = 1'b1; load_len_i = 10'd5;
    step();
    load_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word_valid_i = 1'b1; word_data_i = img[i];
      step();
    end
    word_data_i = img[2];
    abort_i = 1'b1;
    step();
    abort_i = 1'b0; word_valid_i = 1'b0;
    n_chk++; if (word_ready_o !== 1'b0 || busy_o !== 1'b0 || ram_we_o !== 1'b0 || core_rst_n_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_load: ready=%b busy=%b we=%b rst_n=%b done=%b want 0 0 0 0 0",
                         word_ready_o, busy_o, ram_we_o, core_rst_n_o, done_o);
    end
    repeat (3) step();
    n_chk++; if (wr_count !== 2 || mem_model[0] !== img[0] || mem_model[1] !== img[1] || mem_model[2] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL abort_writes: writes=%0d m2=%h want 2 deadbeef", wr_count, mem_model[2]);
    end
  endtask

  task automatic test_abort_run();
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    do_load(3, 0);
    repeat (4) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    n_chk++; if (core_rst_n_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cycles_o !== 32'd0 || core_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_run: rst_n=%b busy=%b done=%b cycles=%0d stall=%b want 0 0 0 0 0",
                         core_rst_n_o, busy_o, done_o, cycles_o, core_stall_o);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    do_load(4, 0);
    repeat (5) step();
    #2;
    rst_n_i = 1'b0;
    #1;
    n_chk++; if (core_rst_n_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== 32'd0 || word_ready_o !== 1'b0 ||
                 done_o !== 1'b0 || core_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: rst_n=%b busy=%b cycles=%0d ready=%b done=%b stall=%b want all 0",
                         core_rst_n_o, busy_o, cycles_o, word_ready_o, done_o, core_stall_o);
    end
    step();
    rst_n_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) img[i] = $urandom;
    do_load(6, 2);
    run_halt($urandom_range(1, 20));
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_halt();
    test_timeout();
    test_ignore_start();
    test_backpressure();
    test_abort_load();
    test_abort_run();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
